uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 4: number of byte requesters, 2..8.
REQ-002 Parameter TMO, default 8: cycles allowed for txrdy to fall after load.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester "byte pending", level.
REQ-006 data  input  8*NREQ  per-requester byte; slice i = data[8i+7:8i].
REQ-007 ack  output  NREQ  one-cycle pulse: byte of requester i taken.
REQ-008 txrdy  input  1  transmit engine ready, level.
REQ-009 load  output  1  one-cycle load strobe to transmit engine.
REQ-010 out_data  output  8  registered byte presented to transmit engine.
REQ-011 grant_id  output  clog2(NREQ)  index of last granted requester.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err  output  1  one-cycle pulse on txrdy timeout.

Function
REQ-014 FSM states IDLE, LOAD, WAIT_LOW, WAIT_HIGH; all outputs registered or decoded from state only.
REQ-015 IDLE: when txrdy=1 and req!=0, select winner g, register out_data<=data slice g, grant_id<=g, go LOAD; otherwise stay.
REQ-016 IDLE with txrdy=0 grants nothing regardless of req.
REQ-017 LOAD: load=1 and ack[g]=1 for exactly this one cycle; next state WAIT_LOW.
REQ-018 Latency: sampling edge in IDLE -> ack/load asserted the next cycle; no combinational path req->ack.
REQ-019 WAIT_LOW: txrdy=0 -> WAIT_HIGH; txrdy still 1 after TMO cycles in WAIT_LOW -> IDLE with err=1 for one cycle.
REQ-020 WAIT_HIGH: txrdy=1 -> IDLE; no timeout (frame length depends on baud).
REQ-021 Round-robin: search starts at grant_id+1, wraps NREQ-1 -> 0; the granted requester becomes lowest priority.
REQ-022 Only one ack bit high in any cycle; ack never asserted outside LOAD.
REQ-023 Requester may keep req high after ack to send the next byte; it shall update its data slice before the next IDLE sample.
REQ-024 req changes outside IDLE are ignored; out_data stable from LOAD through WAIT_HIGH.
REQ-025 Minimum spacing between two loads: 4 cycles (LOAD, WAIT_LOW, WAIT_HIGH, IDLE).

Reset
REQ-026 reset has priority over all transitions and takes effect at the next rising edge, including mid-frame.
REQ-027 Reset values: state IDLE, load 0, ack 0, err 0, busy 0, out_data 8'h00, grant_id NREQ-1 (requester 0 wins first), timeout counter 0.
REQ-028 A byte acked before reset is not retried; a reset in LOAD suppresses nothing already pulsed.

Configuration
REQ-029 Macro UART_TX_SCHED_PRIO_EN defined: req[0] wins whenever asserted in IDLE; requesters 1..NREQ-1 round-robin among themselves, pointer unchanged by grants to 0.
REQ-030 Macro UART_TX_SCHED_PRIO_EN undefined: pure round-robin over all NREQ per REQ-021.

Structure
REQ-031 Shared package holds the FSM state enumeration and TMO default constant.
REQ-032 One sub-module rr_arbiter (combinational request vector + pointer -> one-hot/index winner, with priority-0 option).

Verification
REQ-033 reset, txrdy=1, req=4'b0110, data1=8'h41, data2=8'h42 -> first grant 1 (ack=4'b0010, out_data 8'h41), next grant 2 (8'h42).
REQ-034 req=4'b1111 held, txrdy model drops 1 cycle after load, rises 20 cycles later -> grants 0,1,2,3,0 in order, load spacing 22 cycles.
REQ-035 txrdy=0 in IDLE with req=4'b0001 -> no ack/load until txrdy=1, then ack[0] next cycle.
REQ-036 txrdy stuck 1 after load -> err pulse exactly TMO cycles after WAIT_LOW entry, return IDLE, busy=0.
REQ-037 reset asserted in WAIT_HIGH -> next cycle state IDLE, busy=0, grant_id=3, load=0.
REQ-038 PRIO_EN, req=4'b1110 then req[0] raised after grant 1 -> grant 0 next, then resumes at 2.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit byte scheduler.
`default_nettype none

package uart_tx_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_LOAD      = 2'd1;
  localparam state_t ST_WAIT_LOW  = 2'd2;
  localparam state_t ST_WAIT_HIGH = 2'd3;

  localparam int TMO_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after ptr and wraps;
// with PRIO0 set, requester 0 wins outright and is excluded from the rotation.
`default_nettype none

module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter bit PRIO0 = 1'b0
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic [NREQ-1:0]         onehot
);

  localparam int IW = $clog2(NREQ);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    sum    = '0;
    cand   = '0;
    onehot = '0;
    // Candidates ptr+1 .. ptr+NREQ, so the last winner is checked last.
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      cand = sum[IW-1:0];
      if (!found && req[cand] && !(PRIO0 && (cand == '0))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (PRIO0 && req[0]) begin
      found = 1'b1;
      idx   = '0;
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// Schedules bytes from NREQ requesters into a UART transmit engine.
// Define UART_TX_SCHED_PRIO_EN to give requester 0 absolute priority.
`default_nettype none

module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TMO  = TMO_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       data,
  output logic [NREQ-1:0]         ack,
  input  logic                    txrdy,
  output logic                    load,
  output logic [7:0]              out_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TMO + 1);
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

`ifdef UART_TX_SCHED_PRIO_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] tmo_cnt;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [NREQ-1:0] win_onehot;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PRIO0 (PRIO0)
  ) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .found  (win_found),
    .idx    (win_idx),
    .onehot (win_onehot)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      load     <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      out_data <= 8'h00;
      grant_id <= LAST_ID;
      rr_ptr   <= LAST_ID;
      tmo_cnt  <= '0;
    end else begin
      load <= 1'b0;
      ack  <= '0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (txrdy && win_found) begin
            out_data <= data[8*win_idx +: 8];
            grant_id <= win_idx;
            // Priority grants to requester 0 leave the rotation untouched.
            if (!(PRIO0 && (win_idx == '0))) rr_ptr <= win_idx;
            load  <= 1'b1;
            ack   <= win_onehot;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!txrdy) begin
            state <= ST_WAIT_HIGH;
          end else if (tmo_cnt == CW'(TMO - 1)) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (txrdy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus queues expected grants, a monitor checks each load.
`default_nettype none

module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        txrdy;
  logic        load;
  logic [7:0]  out_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;

  uart_tx_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .txrdy    (txrdy),
    .load     (load),
    .out_data (out_data),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t sbq[$];
  int   load_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // transmit engine model: after a load, txrdy stays high one more cycle,
  // then goes low for eng_low cycles, then returns high
  bit   eng_on  = 1'b0;
  int   eng_low = 1;
  int   eng_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(logic [1:0] g, logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sbq.push_back(e);
  endtask

  // Monitor: every load must match the oldest expected grant.
  always @(negedge clk) begin
    if (!reset) begin
      if (load) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: grant_id %0d data %0h with nothing expected", grant_id, out_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (out_data !== e.d || grant_id !== e.g || ack !== (4'b0001 << e.g)) begin
            errors++;
            $display("FAIL grant: got id %0d data %0h ack %b, expected id %0d data %0h ack %b",
                     grant_id, out_data, ack, e.g, e.d, 4'b0001 << e.g);
          end
        end
      end else if (ack !== 4'b0000) begin
        checks++;
        errors++;
        $display("FAIL ack_without_load: ack %b expected 0000", ack);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (load && !reset) load_cyc.push_back(cyc);
    if (eng_on) begin
      if (load) eng_cnt = eng_low;
      else if (eng_cnt > 0) begin
        txrdy = 1'b0;
        eng_cnt--;
      end else txrdy = 1'b1;
    end
  endtask

  task automatic wait_loads(int n, int budget, string name);
    int start = load_cyc.size();
    int i = 0;
    while ((load_cyc.size() - start) < n && i < budget) begin
      step();
      i++;
    end
    if ((load_cyc.size() - start) < n) chk({name, "_timeout"}, load_cyc.size() - start, n);
  endtask

  task automatic drain(int budget);
    int i = 0;
    while (busy && i < budget) begin
      step();
      i++;
    end
    if (busy) chk("drain_timeout", busy, 0);
  endtask

  task automatic do_reset();
    eng_on  = 1'b0;
    eng_cnt = 0;
    reset   = 1'b1;
    req     = 4'b0000;
    txrdy   = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int s;
    int err_seen;
    int err_at;
    int busy_at_err;
    int busy_before;

    reset = 1'b1;
    req   = 4'b0000;
    txrdy = 1'b0;
    data  = {8'h43, 8'h42, 8'h41, 8'h30};
    step();
    step();
    step();
    chk("rst_load", load, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_grant_id", grant_id, 3);
    reset = 1'b0;

    // two requesters: first grant 1, then 2, back-to-back at minimum spacing
    eng_on = 1'b1; eng_low = 1; eng_cnt = 0; txrdy = 1'b1;
    push(2'd1, 8'h41);
    push(2'd2, 8'h42);
    s = load_cyc.size();
    req = 4'b0110;
    wait_loads(2, 40, "rr2");
    req = 4'b0000;
    if (load_cyc.size() >= s + 2) chk("min_spacing", load_cyc[s+1] - load_cyc[s], 4);
    drain(40);

    // all four requesting, slow engine: 0,1,2,3,0 at 22-cycle spacing
    do_reset();
    eng_on = 1'b1; eng_low = 19; eng_cnt = 0; txrdy = 1'b1;
`ifdef UART_TX_SCHED_PRIO_EN
    for (int i = 0; i < 5; i++) push(2'd0, 8'h30);
`else
    push(2'd0, 8'h30); push(2'd1, 8'h41); push(2'd2, 8'h42);
    push(2'd3, 8'h43); push(2'd0, 8'h30);
`endif
    s = load_cyc.size();
    req = 4'b1111;
    wait_loads(5, 200, "rr4");
    req = 4'b0000;
    if (load_cyc.size() >= s + 5)
      for (int i = 0; i < 4; i++) chk("load_spacing", load_cyc[s+i+1] - load_cyc[s+i], 22);
    drain(60);

    // txrdy low in IDLE holds off the grant
    do_reset();
    txrdy = 1'b0;
    req   = 4'b0001;
    s = load_cyc.size();
    for (int i = 0; i < 6; i++) step();
    chk("hold_no_load", load_cyc.size() - s, 0);
    chk("hold_busy", busy, 0);
    push(2'd0, 8'h30);
    txrdy = 1'b1;
    step();
    chk("release_load", load, 1);
    chk("release_ack", ack, 4'b0001);
    req = 4'b0000;
    eng_on = 1'b1; eng_low = 1; eng_cnt = 1;
    drain(40);

    // txrdy stuck high: err pulse TMO cycles after entering WAIT_LOW
    do_reset();
    txrdy = 1'b1;
    req   = 4'b0001;
    push(2'd0, 8'h30);
    wait_loads(1, 10, "tmo");
    req = 4'b0000;
    err_seen = 0; err_at = -1; busy_at_err = -1; busy_before = -1;
    for (int j = 1; j <= TMO + 3; j++) begin
      step();
      if (j == TMO) busy_before = busy;
      if (err) begin
        err_seen++;
        if (err_at < 0) begin
          err_at = j;
          busy_at_err = busy;
        end
      end
    end
    chk("tmo_err_cycle", err_at, TMO + 1);
    chk("tmo_err_pulses", err_seen, 1);
    chk("tmo_busy_before", busy_before, 1);
    chk("tmo_busy_after", busy_at_err, 0);

    // reset in WAIT_HIGH
    do_reset();
    eng_on = 1'b1; eng_low = 10; eng_cnt = 0; txrdy = 1'b1;
    req = 4'b0001;
    push(2'd0, 8'h30);
    wait_loads(1, 10, "midrst");
    req = 4'b0000;
    step();
    step();
    step();
    chk("midrst_busy_pre", busy, 1);
    eng_on = 1'b0;
    reset  = 1'b1;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_grant_id", grant_id, 3);
    chk("midrst_load", load, 0);
    chk("midrst_ack", ack, 0);
    reset = 1'b0;
    txrdy = 1'b1;

`ifdef UART_TX_SCHED_PRIO_EN
    // requester 0 jumps the queue, rotation resumes after 1
    do_reset();
    eng_on = 1'b1; eng_low = 1; eng_cnt = 0; txrdy = 1'b1;
    push(2'd1, 8'h41);
    req = 4'b1110;
    wait_loads(1, 20, "prio_a");
    req = 4'b1111;
    push(2'd0, 8'h30);
    push(2'd2, 8'h42);
    wait_loads(2, 40, "prio_b");
    req = 4'b0000;
    drain(40);
`endif

    for (int i = 0; i < 4; i++) step();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
